// File: rtl/snn_layer_argmax_if.sv
// Bus bundle between the output-layer classifier and its memories/controller.
// The slave side is the classifier; the master side owns start and the RAM/ROM data.
interface snn_layer_argmax_if #(
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 18,
  parameter int IN_ADDR_W = 10,
  parameter int W_ADDR_W  = 13,
  parameter int OUT_W     = 4
) ();
  logic                        start;
  logic                        q_input;
  logic signed [W_WIDTH-1:0]   q_weight;
  logic [IN_ADDR_W-1:0]        addr_input_unit;
  logic [W_ADDR_W-1:0]         addr_weight;
  logic                        busy;
  logic                        done;
  logic [OUT_W-1:0]            digit;
  logic signed [ACC_WIDTH-1:0] max_score;
  logic                        saturated;

  modport slave (
    input  start, q_input, q_weight,
    output addr_input_unit, addr_weight, busy, done, digit, max_score, saturated
  );

  modport master (
    output start, q_input, q_weight,
    input  addr_input_unit, addr_weight, busy, done, digit, max_score, saturated
  );
endinterface

// File: rtl/snn_layer_argmax.sv
// Fully-connected output layer with saturating accumulators and argmax classifier.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for start, addresses parked at 0
// S_MAC   | stream inputs i=0..N_IN-1 for neuron n, accumulate lagged data
// S_DRAIN | accumulate the last input (memory read latency)
// S_CMP   | compare acc against best, advance to next neuron or finish
// S_DONE  | publish digit/max_score, done pulse follows
module snn_layer_argmax #(
  parameter int N_IN      = 784,
  parameter int N_OUT     = 10,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 18,
  parameter int IN_ADDR_W = 10,
  parameter int W_ADDR_W  = 13,
  parameter int OUT_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  snn_layer_argmax_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_CMP, S_DONE} state_t;

  localparam logic [IN_ADDR_W-1:0] LAST_I = IN_ADDR_W'(N_IN - 1);
  localparam logic [OUT_W-1:0]     LAST_N = OUT_W'(N_OUT - 1);
  localparam logic [W_ADDR_W-1:0]  STRIDE = W_ADDR_W'(N_IN);

  state_t                      r_state, w_next;
  logic [IN_ADDR_W-1:0]        r_i;
  logic [OUT_W-1:0]            r_n, r_best_idx, r_digit;
  logic [W_ADDR_W-1:0]         r_wbase;
  logic signed [ACC_WIDTH-1:0] r_acc, r_best, r_max_score;
  logic                        r_sat, r_busy, r_done;

  logic                        w_acc_en, w_clip;
  logic [ACC_WIDTH:0]          w_sum;
  logic [ACC_WIDTH-1:0]        w_acc_next;

  // Data arrives one cycle after its address, so the first MAC cycle has nothing to add.
  assign w_acc_en = bus.q_input &&
                    (((r_state == S_MAC) && (r_i != '0)) || (r_state == S_DRAIN));
  assign w_sum    = {r_acc[ACC_WIDTH-1], r_acc} +
                    {{(ACC_WIDTH + 1 - W_WIDTH){bus.q_weight[W_WIDTH-1]}}, bus.q_weight};
  assign w_clip   = w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1];
  assign w_acc_next = !w_clip         ? w_sum[ACC_WIDTH-1:0] :
                      w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                         {1'b0, {(ACC_WIDTH-1){1'b1}}};

  assign bus.addr_input_unit = (r_state == S_MAC) ? r_i : '0;
  assign bus.addr_weight     = (r_state == S_MAC) ? (r_wbase + W_ADDR_W'(r_i)) : '0;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.digit           = r_digit;
  assign bus.max_score       = r_max_score;
  assign bus.saturated       = r_sat;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state sequencing through MAC/DRAIN/CMP once per neuron.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_MAC;
      S_MAC:   if (r_i == LAST_I) w_next = S_DRAIN;
      S_DRAIN: w_next = S_CMP;
      S_CMP:   w_next = (r_n == LAST_N) ? S_DONE : S_MAC;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Counters, saturating accumulator, running argmax and published results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i         <= '0;
      r_n         <= '0;
      r_wbase     <= '0;
      r_acc       <= '0;
      r_best      <= '0;
      r_best_idx  <= '0;
      r_digit     <= '0;
      r_max_score <= '0;
      r_sat       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_acc_en) begin
        r_acc <= w_acc_next;
        if (w_clip) r_sat <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_i     <= '0;
            r_n     <= '0;
            r_wbase <= '0;
            r_acc   <= '0;
            r_sat   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_MAC: begin
          if (r_i != LAST_I) r_i <= r_i + 1'b1;
        end
        S_CMP: begin
          // Strict compare: ties keep the lower neuron index.
          if ((r_n == '0) || (r_acc > r_best)) begin
            r_best     <= r_acc;
            r_best_idx <= r_n;
          end
          if (r_n != LAST_N) begin
            r_n     <= r_n + 1'b1;
            r_i     <= '0;
            r_acc   <= '0;
            r_wbase <= r_wbase + STRIDE;
          end
        end
        S_DONE: begin
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_digit     <= r_best_idx;
          r_max_score <= r_best;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_snn_layer_argmax.sv
// Scoreboard bench: a large (784x10) and a small (16x4, narrow accumulator) instance.
module tb_snn_layer_argmax;
  localparam int DN_IN = 784, DN_OUT = 10, DACC = 18;
  localparam int SN_IN = 16,  SN_OUT = 4,  SACC = 10;
  localparam int D_LAT = DN_OUT * (DN_IN + 2) + 1;
  localparam int S_LAT = SN_OUT * (SN_IN + 2) + 1;

  typedef struct packed {
    int     digit;
    longint score;
    bit     sat;
    longint cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_d, rst_s;
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;
  exp_t   q_d[$];
  exp_t   q_s[$];
  bit     in_d[];
  int     w_d[];
  bit     in_s[];
  int     w_s[];

  snn_layer_argmax_if #(.W_WIDTH(8), .ACC_WIDTH(DACC), .IN_ADDR_W(10), .W_ADDR_W(13), .OUT_W(4)) bus_d ();
  snn_layer_argmax_if #(.W_WIDTH(8), .ACC_WIDTH(SACC), .IN_ADDR_W(4),  .W_ADDR_W(6),  .OUT_W(2)) bus_s ();

  snn_layer_argmax #(.N_IN(DN_IN), .N_OUT(DN_OUT), .W_WIDTH(8), .ACC_WIDTH(DACC),
                     .IN_ADDR_W(10), .W_ADDR_W(13), .OUT_W(4))
    u_dut_d (.clk(clk), .rst_n(rst_d), .bus(bus_d));

  snn_layer_argmax #(.N_IN(SN_IN), .N_OUT(SN_OUT), .W_WIDTH(8), .ACC_WIDTH(SACC),
                     .IN_ADDR_W(4), .W_ADDR_W(6), .OUT_W(2))
    u_dut_s (.clk(clk), .rst_n(rst_s), .bus(bus_s));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memories: data valid one cycle after the address.
  always @(posedge clk) begin
    bus_d.q_input  <= in_d[bus_d.addr_input_unit];
    bus_d.q_weight <= 8'(w_d[bus_d.addr_weight]);
    bus_s.q_input  <= in_s[bus_s.addr_input_unit];
    bus_s.q_weight <= 8'(w_s[bus_s.addr_weight]);
  end

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: per neuron, clamped running sum over active inputs; first strict maximum wins.
  function automatic exp_t model(input bit inp[], input int w[], input int nin, input int nout, input int accw);
    exp_t   e;
    longint lo, hi, s, best;
    lo = -(longint'(1) <<< (accw - 1));
    hi = -lo - 1;
    e = '0;
    best = 0;
    for (int n = 0; n < nout; n++) begin
      s = 0;
      for (int i = 0; i < nin; i++) begin
        if (inp[i]) begin
          s = s + w[n * nin + i];
          if (s > hi) begin s = hi; e.sat = 1'b1; end
          else if (s < lo) begin s = lo; e.sat = 1'b1; end
        end
      end
      if (n == 0 || s > best) begin
        best = s;
        e.digit = n;
      end
    end
    e.score = best;
    return e;
  endfunction

  // Monitors: pop expected result whenever a done pulse is presented.
  always @(negedge clk) begin
    exp_t e;
    if (bus_d.done === 1'b1) begin
      if (q_d.size() == 0) begin
        checks++; errors++;
        $display("FAIL d_unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e = q_d.pop_front();
        chk("d_digit", bus_d.digit, e.digit);
        chk("d_score", bus_d.max_score, e.score);
        chk("d_sat", bus_d.saturated, e.sat);
        chk("d_done_cycle", cyc, e.cyc);
        chk("d_busy_at_done", bus_d.busy, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus_s.done === 1'b1) begin
      if (q_s.size() == 0) begin
        checks++; errors++;
        $display("FAIL s_unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e = q_s.pop_front();
        chk("s_digit", bus_s.digit, e.digit);
        chk("s_score", bus_s.max_score, e.score);
        chk("s_sat", bus_s.saturated, e.sat);
        chk("s_done_cycle", cyc, e.cyc);
        chk("s_busy_at_done", bus_s.busy, 0);
      end
    end
  end

  task automatic check_idle(input bit sel, input string name);
    if (sel) begin
      chk({name, "_digit"}, bus_d.digit, 0);
      chk({name, "_score"}, bus_d.max_score, 0);
      chk({name, "_sat"}, bus_d.saturated, 0);
      chk({name, "_done"}, bus_d.done, 0);
      chk({name, "_busy"}, bus_d.busy, 0);
      chk({name, "_addr_in"}, bus_d.addr_input_unit, 0);
      chk({name, "_addr_w"}, bus_d.addr_weight, 0);
    end else begin
      chk({name, "_digit"}, bus_s.digit, 0);
      chk({name, "_score"}, bus_s.max_score, 0);
      chk({name, "_sat"}, bus_s.saturated, 0);
      chk({name, "_done"}, bus_s.done, 0);
      chk({name, "_busy"}, bus_s.busy, 0);
      chk({name, "_addr_in"}, bus_s.addr_input_unit, 0);
      chk({name, "_addr_w"}, bus_s.addr_weight, 0);
    end
  endtask

  // Pulse start for one cycle and queue the expected result; returns the expected done cycle.
  task automatic start_run(input bit sel, output longint done_cyc);
    exp_t e;
    @(negedge clk);
    if (sel) begin
      e = model(in_d, w_d, DN_IN, DN_OUT, DACC);
      e.cyc = cyc + 1 + D_LAT;
      q_d.push_back(e);
      bus_d.start = 1'b1;
    end else begin
      e = model(in_s, w_s, SN_IN, SN_OUT, SACC);
      e.cyc = cyc + 1 + S_LAT;
      q_s.push_back(e);
      bus_s.start = 1'b1;
    end
    done_cyc = e.cyc;
    @(negedge clk);
    bus_d.start = 1'b0;
    bus_s.start = 1'b0;
    if (sel) chk("d_busy_after_start", bus_d.busy, 1);
    else     chk("s_busy_after_start", bus_s.busy, 1);
  endtask

  task automatic wait_run(input bit sel);
    int t = 0;
    int lim;
    lim = sel ? (2 * D_LAT + 20) : (2 * S_LAT + 20);
    while ((sel ? q_d.size() : q_s.size()) != 0 && t < lim) begin
      @(negedge clk);
      t++;
    end
    if ((sel ? q_d.size() : q_s.size()) != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done within %0d cycles expected done", sel ? "d" : "s", lim);
      if (sel) q_d.delete(); else q_s.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_s(input bit full_range);
    for (int i = 0; i < SN_IN; i++) in_s[i] = 1'($urandom_range(0, 1));
    for (int k = 0; k < SN_IN * SN_OUT; k++)
      w_s[k] = full_range ? (int'($urandom_range(0, 255)) - 128) : (int'($urandom_range(0, 40)) - 20);
  endtask

  initial begin
    longint dc;
    exp_t   e1, e2;
    in_d = new[1024];
    w_d  = new[8192];
    in_s = new[16];
    w_s  = new[64];
    bus_d.start = 1'b0;
    bus_s.start = 1'b0;
    rst_d = 1'b0;
    rst_s = 1'b0;
    repeat (3) @(negedge clk);
    check_idle(1'b1, "d_reset");
    check_idle(1'b0, "s_reset");
    rst_d = 1'b1;
    rst_s = 1'b1;
    @(negedge clk);

    // Large instance: single winner at neuron 3.
    for (int i = 0; i < DN_IN; i++) in_d[i] = 1'b1;
    for (int k = 0; k < DN_IN * DN_OUT; k++) w_d[k] = (k / DN_IN == 3) ? 1 : 0;
    start_run(1'b1, dc);
    wait_run(1'b1);
    // Tie between neurons 2 and 7.
    for (int k = 0; k < DN_IN * DN_OUT; k++) w_d[k] = (k / DN_IN == 2 || k / DN_IN == 7) ? 2 : 1;
    start_run(1'b1, dc);
    wait_run(1'b1);
    // All-negative scores.
    for (int k = 0; k < DN_IN * DN_OUT; k++) w_d[k] = -(k / DN_IN + 1);
    start_run(1'b1, dc);
    wait_run(1'b1);
    // No active inputs.
    for (int i = 0; i < DN_IN; i++) in_d[i] = 1'b0;
    start_run(1'b1, dc);
    wait_run(1'b1);
    // Random large run.
    for (int i = 0; i < DN_IN; i++) in_d[i] = 1'($urandom_range(0, 1));
    for (int k = 0; k < DN_IN * DN_OUT; k++) w_d[k] = int'($urandom_range(0, 255)) - 128;
    start_run(1'b1, dc);
    wait_run(1'b1);

    // Small instance: alternating inputs, weight n per neuron.
    for (int i = 0; i < SN_IN; i++) in_s[i] = (i % 2 == 0);
    for (int k = 0; k < SN_IN * SN_OUT; k++) w_s[k] = k / SN_IN;
    start_run(1'b0, dc);
    wait_run(1'b0);
    // Saturation with narrow accumulator, then cleared on a clean rerun.
    for (int i = 0; i < SN_IN; i++) in_s[i] = 1'b1;
    for (int k = 0; k < SN_IN * SN_OUT; k++) w_s[k] = 127;
    start_run(1'b0, dc);
    wait_run(1'b0);
    repeat (3) @(negedge clk);
    chk("s_sat_hold", bus_s.saturated, 1);
    for (int k = 0; k < SN_IN * SN_OUT; k++) w_s[k] = 0;
    start_run(1'b0, dc);
    wait_run(1'b0);
    // Negative saturation.
    for (int k = 0; k < SN_IN * SN_OUT; k++) w_s[k] = -128;
    start_run(1'b0, dc);
    wait_run(1'b0);

    // Random small runs.
    for (int r = 0; r < 25; r++) begin
      rand_s(r % 3 == 0);
      start_run(1'b0, dc);
      wait_run(1'b0);
    end

    // Start held high re-triggers as soon as IDLE is reached.
    rand_s(1'b0);
    @(negedge clk);
    e1 = model(in_s, w_s, SN_IN, SN_OUT, SACC);
    e1.cyc = cyc + 1 + S_LAT;
    e2 = e1;
    e2.cyc = e1.cyc + 1 + S_LAT;
    q_s.push_back(e1);
    q_s.push_back(e2);
    bus_s.start = 1'b1;
    while (cyc < e1.cyc + 1) @(negedge clk);
    bus_s.start = 1'b0;
    chk("s_busy_retrigger", bus_s.busy, 1);
    wait_run(1'b0);

    // Start pulses mid-MAC and in the DONE cycle are ignored.
    rand_s(1'b1);
    start_run(1'b0, dc);
    repeat (8) @(negedge clk);
    bus_s.start = 1'b1;
    @(negedge clk);
    bus_s.start = 1'b0;
    while (cyc < dc - 1) @(negedge clk);
    bus_s.start = 1'b1;
    @(negedge clk);
    bus_s.start = 1'b0;
    wait_run(1'b0);
    repeat (S_LAT + 5) @(negedge clk);
    chk("s_busy_after_ignored_start", bus_s.busy, 0);

    // Reset mid-run aborts with no done, then a fresh run is correct.
    rand_s(1'b0);
    start_run(1'b0, dc);
    repeat (20) @(negedge clk);
    rst_s = 1'b0;
    q_s.delete();
    #1;
    check_idle(1'b0, "s_midrun_reset");
    @(negedge clk);
    rst_s = 1'b1;
    repeat (S_LAT + 5) @(negedge clk);
    chk("s_busy_after_abort", bus_s.busy, 0);
    rand_s(1'b1);
    start_run(1'b0, dc);
    wait_run(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
